// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for the execute stage: retires BITS_PER_CYCLE
// multiplier bits per cycle and stalls the front of the pipeline until the low XLEN product is ready.
module mul_iter_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      ALUControlE,
    input  logic            ValidE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            StallMul,
    output logic            MulDoneE,
    output logic [XLEN-1:0] MulResultE
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0]    MUL_CODE = 4'b1010;
    localparam logic [CW-1:0] LAST     = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] partial;
    logic [CW-1:0]   cnt;
    logic            is_mul;

    assign is_mul = ValidE & ~FlushE & (ALUControlE == MUL_CODE);

    // multiplicand times the low BITS_PER_CYCLE multiplier bits, as a small shift-add
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    always_comb begin
        state_next = state;
        StallMul   = 1'b0;
        MulDoneE   = 1'b0;
        MulResultE = result_q;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    state_next = BUSY;
                    StallMul   = 1'b1;
                end
            end
            BUSY: begin
                StallMul = 1'b1;
                if (FlushE) begin
                    state_next = IDLE;
                end else if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (!FlushE) begin
                    MulDoneE   = 1'b1;
                    MulResultE = acc;
                end
            end
            default: state_next = IDLE;
        endcase
        // outputs read as zero throughout the reset cycle, whatever state it interrupts
        if (reset) begin
            StallMul   = 1'b0;
            MulDoneE   = 1'b0;
            MulResultE = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        mcand  <= SrcAE;
                        mplier <= SrcBE;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + CW'(1);
                end
                DONE: begin
                    // keeps the product visible after the done pulse
                    if (!FlushE) begin
                        result_q <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_iter_unit.md
# mul_iter_unit

Iterative multiplier in the execute stage, downstream of the ALU decoder. It consumes the 4-bit ALU control code and, on code `4'b1010` (mul), computes the low XLEN bits of `SrcAE * SrcBE` over multiple cycles. It holds the front of the pipeline through a stall request until the product is ready. The ALU result mux selects `MulResultE` when the code is mul.

## Interface
- `XLEN`, 32: operand and result width.
- `BITS_PER_CYCLE`, 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4. `XLEN % BITS_PER_CYCLE == 0`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ALUControlE`  in  4  ALU control code of the instruction in E. Mul is `4'b1010`.
- `ValidE`  in  1  the E-stage instruction is real, not a bubble.
- `FlushE`  in  1  the E-stage instruction is being squashed this cycle.
- `SrcAE`  in  XLEN  multiplicand, after forwarding.
- `SrcBE`  in  XLEN  multiplier, after forwarding.
- `StallMul`  out  1  hold F, D and E and bubble M. The hazard unit ORs this into its stall outputs.
- `MulDoneE`  out  1  `MulResultE` is valid this cycle and the mul leaves E at the next edge.
- `MulResultE`  out  XLEN  product, low XLEN bits.

## Operation
- Definitions: `N = XLEN/BITS_PER_CYCLE`; `isMul = ValidE & ~FlushE & (ALUControlE == 4'b1010)`.
- State machine states: IDLE, BUSY, DONE. Reset goes to IDLE.
- IDLE:
  - If `isMul`: latch the operands (multiplicand register = `SrcAE`, multiplier register = `SrcBE`), clear the accumulator and counter, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each cycle:
  - `acc += multiplicand * multiplier[BITS_PER_CYCLE-1:0]`, truncated to XLEN.
  - Shift the multiplicand left by BITS_PER_CYCLE, shift the multiplier right by BITS_PER_CYCLE (logical), and increment the counter.
  - When the counter reaches N-1 in BUSY, go to DONE.
- DONE:
  - `MulResultE = acc` and `MulDoneE = 1`.
  - Return to IDLE unconditionally. This suppresses a restart on the same instruction while it is still in E.
- Arithmetic: the result is `(SrcAE * SrcBE) mod 2^XLEN`. Signedness does not affect the low half, so no sign handling is needed.
- `StallMul = ~reset & ((state==IDLE & isMul) | state==BUSY)`. It is combinational, so the stall takes effect in the start cycle.
- Operands are sampled only in the IDLE start cycle. Forwarded values that change afterwards are ignored.
- `FlushE` in BUSY or DONE aborts to IDLE: no `MulDoneE`, accumulator value discarded. `FlushE` in IDLE blocks a start.
- Non-mul codes never stall and never disturb the state. `MulResultE` holds its last value outside DONE; consumers gate on `MulDoneE`.
- Reset at any time, including mid-BUSY, gives: state IDLE, accumulator, counter and operand registers 0, and `StallMul`, `MulDoneE` and `MulResultE` all 0 in the reset cycle and the cycle after.

## Timing
- Cycle t (IDLE, `isMul`): `StallMul=1`, operands latched at the edge ending cycle t.
- Cycles t+1 .. t+N (BUSY): `StallMul=1`.
- Cycle t+N+1 (DONE): `StallMul=0`, `MulDoneE=1`, result valid. The mul advances to M at the end of this cycle.
- Totals:
  - Stall cycles: N+1.
  - Cycles the mul occupies E: N+2.
  - XLEN=32, BITS_PER_CYCLE=1: 33 stall cycles, 34 cycles in E.
  - BITS_PER_CYCLE=4: 9 stall cycles, 10 cycles in E.
- Back-to-back muls: the second mul is in IDLE with `isMul` at cycle t+N+2 and starts immediately. There is no extra dead cycle beyond DONE.
- `MulDoneE` is a one-cycle pulse per completed mul and is never asserted in consecutive cycles.

## Test plan
- Basic product: `SrcAE=7`, `SrcBE=6`, mul code, `ValidE=1`, defaults. Required: `StallMul` high for 33 cycles, then `MulDoneE=1` with `MulResultE=42` for exactly one cycle, then `StallMul=0` and state IDLE.
- Width and sign edge cases:
  - `0xFFFFFFFF * 0xFFFFFFFF` gives 1.
  - `0x80000000 * 2` gives 0.
  - `0x12345678 * 0x9ABCDEF0` gives `0x242D2080`.
  - Repeat all three with `BITS_PER_CYCLE=2` and `BITS_PER_CYCLE=4`; results must match, with 17 and 9 stall cycles respectively.
- Back-to-back: mul `3*5`, then mul `4*4` entering E the cycle after DONE. Required: `MulDoneE` pulses with 15, then with 16, exactly 34 cycles apart. `SrcAE` changing during BUSY must not affect the result.
- Non-mul codes: `ALUControlE` in {0000, 0001, 0110, 1001} with `ValidE=1`, and the mul code with `ValidE=0`. Required: `StallMul=0` and `MulDoneE=0` every cycle.
- Abort by flush: start `9*9`, assert `FlushE` at BUSY cycle 10. Required: `StallMul=0` the next cycle, no `MulDoneE`. A following mul `2*3` completes normally with 6.
- Abort by reset: assert `reset` mid-BUSY for one cycle. Required: all outputs 0, state IDLE. A subsequent `10*10` returns 100 after the full latency.
